// File: rtl/color_centroid_tracker_if.sv
// Pixel-side inputs and mouse-side outputs of the colour centroid tracker.
// The master side drives the detector/VGA timing; the slave is the tracker.
interface color_centroid_tracker_if;
  logic       pix_valid;
  logic       vs_in;
  logic       green_hit;
  logic       red_hit;
  logic [9:0] cursor_x;
  logic [8:0] cursor_y;
  logic       present;
  logic       click;
  logic       cursor_valid;
  logic       frame_drop;

  modport master (
    output pix_valid, vs_in, green_hit, red_hit,
    input  cursor_x, cursor_y, present, click, cursor_valid, frame_drop
  );

  modport slave (
    input  pix_valid, vs_in, green_hit, red_hit,
    output cursor_x, cursor_y, present, click, cursor_valid, frame_drop
  );
endinterface

// File: rtl/color_centroid_tracker.sv
// Accumulates green-hit coordinates per frame and divides out the blob centroid
// during vertical blanking; red-hit count drives the click flag.
module color_centroid_tracker #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned HIT_LATENCY = 2,
  parameter int unsigned MIN_PIXELS  = 16,
  parameter int unsigned CLICK_MIN   = 64,
  parameter int unsigned DIV_BITS    = 28
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  color_centroid_tracker_if.slave  bus
);

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned RW = 19;
  localparam int unsigned SW = DIV_BITS + 1;
  localparam int unsigned IW = $clog2(DIV_BITS);

  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [HIT_LATENCY-1:0] r_pv_dly;
  logic                   r_vs_q;
  logic [XW-1:0]          r_x;
  logic [YW-1:0]          r_y;
  logic                   r_end;
  logic [DIV_BITS-1:0]    r_sum_x, r_sum_y, r_g_cnt;
  logic [RW-1:0]          r_r_cnt;
  logic [IW-1:0]          r_iter;
  logic [DIV_BITS-1:0]    r_div_g, r_q_x, r_q_y, r_rem_x, r_rem_y;
  logic [RW-1:0]          r_r_snap;
  logic [XW-1:0]          r_cursor_x;
  logic [YW-1:0]          r_cursor_y;
  logic                   r_present, r_click, r_cursor_valid, r_frame_drop;

  logic                   w_dv, w_frame_end, w_x_last, w_y_last, w_div_last;
  logic [SW-1:0]          w_sum_x_add, w_sum_y_add;
  logic [SW-1:0]          w_x_sh, w_y_sh, w_x_sub, w_y_sub;
  logic                   w_x_ge, w_y_ge;

  assign w_dv        = r_pv_dly[HIT_LATENCY-1] & ~r_end;
  assign w_frame_end = r_vs_q & ~bus.vs_in;
  assign w_x_last    = (r_x == XW'(H_ACTIVE - 1));
  assign w_y_last    = (r_y == YW'(V_ACTIVE - 1));
  assign w_div_last  = (r_iter == IW'(DIV_BITS - 1));

  assign w_sum_x_add = {1'b0, r_sum_x} + SW'(r_x);
  assign w_sum_y_add = {1'b0, r_sum_y} + SW'(r_y);

  // One restoring-division step per cycle for both axes, shared divisor.
  assign w_x_sh  = {r_rem_x, r_q_x[DIV_BITS-1]};
  assign w_y_sh  = {r_rem_y, r_q_y[DIV_BITS-1]};
  assign w_x_ge  = (w_x_sh >= {1'b0, r_div_g});
  assign w_y_ge  = (w_y_sh >= {1'b0, r_div_g});
  assign w_x_sub = w_x_sh - {1'b0, r_div_g};
  assign w_y_sub = w_y_sh - {1'b0, r_div_g};

  assign bus.cursor_x     = r_cursor_x;
  assign bus.cursor_y     = r_cursor_y;
  assign bus.present      = r_present;
  assign bus.click        = r_click;
  assign bus.cursor_valid = r_cursor_valid;
  assign bus.frame_drop   = r_frame_drop;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= ST_ACCUM;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM:  if (w_frame_end) w_state_nxt = ST_DIVIDE;
      ST_DIVIDE: if (w_div_last)  w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_ACCUM;
      default:   w_state_nxt = ST_ACCUM;
    endcase
  end

  // Pixel strobe alignment, raster position and per-frame accumulation.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_vs_q   <= 1'b1;
      r_pv_dly <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_end    <= 1'b0;
      r_sum_x  <= '0;
      r_sum_y  <= '0;
      r_g_cnt  <= '0;
      r_r_cnt  <= '0;
    end else begin
      r_vs_q <= bus.vs_in;
      if (w_frame_end) begin
        r_pv_dly <= '0;
        r_x      <= '0;
        r_y      <= '0;
        r_end    <= 1'b0;
        r_sum_x  <= '0;
        r_sum_y  <= '0;
        r_g_cnt  <= '0;
        r_r_cnt  <= '0;
      end else begin
        r_pv_dly[0] <= bus.pix_valid;
        for (int i = 1; i < int'(HIT_LATENCY); i++) r_pv_dly[i] <= r_pv_dly[i-1];
        if (w_dv) begin
          if (bus.green_hit) begin
            r_sum_x <= w_sum_x_add[DIV_BITS] ? '1 : w_sum_x_add[DIV_BITS-1:0];
            r_sum_y <= w_sum_y_add[DIV_BITS] ? '1 : w_sum_y_add[DIV_BITS-1:0];
            if (r_g_cnt != '1) r_g_cnt <= r_g_cnt + 1'b1;
          end
          if (bus.red_hit && r_r_cnt != '1) r_r_cnt <= r_r_cnt + 1'b1;
          if (!w_x_last) begin
            r_x <= r_x + 1'b1;
          end else if (w_y_last) begin
            r_end <= 1'b1;
          end else begin
            r_x <= '0;
            r_y <= r_y + 1'b1;
          end
        end
      end
    end
  end

  // Snapshot, serial divide and output publication.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_iter         <= '0;
      r_div_g        <= '0;
      r_q_x          <= '0;
      r_q_y          <= '0;
      r_rem_x        <= '0;
      r_rem_y        <= '0;
      r_r_snap       <= '0;
      r_cursor_x     <= '0;
      r_cursor_y     <= '0;
      r_present      <= 1'b0;
      r_click        <= 1'b0;
      r_cursor_valid <= 1'b0;
      r_frame_drop   <= 1'b0;
    end else begin
      r_cursor_valid <= 1'b0;
      r_frame_drop   <= 1'b0;
      case (r_state)
        ST_ACCUM: begin
          if (w_frame_end) begin
            r_q_x    <= r_sum_x;
            r_q_y    <= r_sum_y;
            r_div_g  <= r_g_cnt;
            r_r_snap <= r_r_cnt;
            r_rem_x  <= '0;
            r_rem_y  <= '0;
            r_iter   <= '0;
          end
        end
        ST_DIVIDE: begin
          r_frame_drop <= w_frame_end;
          r_rem_x <= DIV_BITS'(w_x_ge ? w_x_sub : w_x_sh);
          r_rem_y <= DIV_BITS'(w_y_ge ? w_y_sub : w_y_sh);
          r_q_x   <= {r_q_x[DIV_BITS-2:0], w_x_ge};
          r_q_y   <= {r_q_y[DIV_BITS-2:0], w_y_ge};
          r_iter  <= r_iter + 1'b1;
        end
        ST_DONE: begin
          r_frame_drop   <= w_frame_end;
          r_cursor_valid <= 1'b1;
          r_click        <= (r_r_snap >= RW'(CLICK_MIN));
          if (r_div_g >= DIV_BITS'(MIN_PIXELS)) begin
            r_present  <= 1'b1;
            r_cursor_x <= XW'(r_q_x);
            r_cursor_y <= YW'(r_q_y);
          end else begin
            r_present  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
